// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one partial-product step per clock,
// full signed 2*WIDTH-bit product delivered on hi/lo with a one-cycle multStop strobe.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    input  logic             multInit,
    output logic             multStop,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, next;

    // A and M carry one guard bit so A-M cannot overflow for the most negative M
    logic [WIDTH:0]   a_reg;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             last;

    always_comb begin
        sum = a_reg;
        unique case ({q_reg[0], q1})
            2'b01:   sum = a_reg + m_reg;
            2'b10:   sum = a_reg - m_reg;
            default: sum = a_reg;
        endcase
        a_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt = {sum[0], q_reg[WIDTH-1:1]};
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next     = state;
        busy     = 1'b0;
        multStop = 1'b0;
        unique case (state)
            IDLE: begin
                if (multInit) next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) next = DONE;
            end
            DONE: begin
                multStop = 1'b1;
                next     = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            q1    <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (multInit) begin
                        m_reg <= {value_A[WIDTH-1], value_A};
                        q_reg <= value_B;
                        a_reg <= '0;
                        q1    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q1    <= q_reg[0];
                    cnt   <= cnt + CW'(1);
                    // result registers only move on the final step, so the
                    // previous product stays readable throughout the run
                    if (last) begin
                        hi <= a_nxt[WIDTH-1:0];
                        lo <= q_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: expected products come from plain 64-bit
// signed multiplication; a cycle-level model predicts busy/multStop timing.
module tb_booth_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value_A = '0;
    logic [31:0] value_B = '0;
    logic        multInit = 1'b0;
    logic        multStop;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    booth_mult #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_A  (value_A),
        .value_B  (value_B),
        .multInit (multInit),
        .multStop (multStop),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    logic [63:0] sb_q[$];
    logic [63:0] held = '0;
    int unsigned rem = 0;
    bit          armed = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stops = 0;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        longint p;
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        return 64'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation model: 33 cycles after acceptance (32 busy + 1 done), idle otherwise.
    always @(posedge clk) begin
        if (!reset) begin
            sb_q.delete();
            rem   = 0;
            held  = '0;
            armed = 1;
        end else if (rem == 0) begin
            if (multInit) begin
                sb_q.push_back(ref_prod(value_A, value_B));
                rem = 33;
            end
        end else begin
            rem = rem - 1;
        end
    end

    // Monitor: timing checked every cycle, product popped whenever multStop appears.
    always @(negedge clk) begin
        if (armed) begin
            check("busy", 64'(busy), 64'(rem >= 2));
            check("multStop", 64'(multStop), 64'(rem == 1));
            if (multStop) begin
                stops++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_multStop: got hi=%h lo=%h expected no result at %0t", hi, lo, $time);
                end else begin
                    held = sb_q.pop_front();
                end
            end
            check("hilo", {hi, lo}, held);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (rem != 0 && k < 200) begin
            tick(1);
            k++;
        end
        if (rem != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got rem=%0d expected 0", rem);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        value_A  = a;
        value_B  = b;
        multInit = 1'b1;
        tick(1);
        multInit = 1'b0;
    endtask

    logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        int s0;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0;
        tick(2);
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy", 64'({busy, multStop}), 64'h0);
        reset = 1'b1;
        tick(1);

        start(32'd3, 32'd5);
        wait_idle();
        check("p3x5", {hi, lo}, 64'h0000_0000_0000_000F);

        start(32'hFFFF_FFF9, 32'd6);
        wait_idle();
        check("pm7x6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("pm1xm1", {hi, lo}, 64'h0000_0000_0000_0001);

        start(32'h8000_0000, 32'h8000_0000);
        wait_idle();
        check("pminxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        start(32'h7FFF_FFFF, 32'h8000_0000);
        wait_idle();
        check("pmaxxmin", {hi, lo}, 64'hC000_0000_8000_0000);

        // multInit and operand changes mid-run are ignored
        s0 = stops;
        start(32'd3, 32'd5);
        tick(9);
        value_A  = 32'd9;
        value_B  = 32'd9;
        multInit = 1'b1;
        tick(1);
        multInit = 1'b0;
        value_A  = 32'd123;
        value_B  = 32'd456;
        wait_idle();
        tick(5);
        check("ignore_result", {hi, lo}, 64'h0000_0000_0000_000F);
        check("ignore_stops", 64'(stops - s0), 64'd1);

        // reset aborts a run
        s0 = stops;
        start(32'd3, 32'd5);
        tick(19);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("abort_hilo", {hi, lo}, 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        tick(40);
        check("abort_stops", 64'(stops - s0), 64'd0);
        start(32'd4, 32'd4);
        wait_idle();
        check("p4x4", {hi, lo}, 64'h0000_0000_0000_0010);

        // multInit held high: back-to-back operations
        s0 = stops;
        value_A  = 32'd2;
        value_B  = 32'd2;
        multInit = 1'b1;
        tick(3 * 34 + 5);
        multInit = 1'b0;
        wait_idle();
        check("b2b_result", {hi, lo}, 64'h0000_0000_0000_0004);
        check("b2b_stops", 64'(stops - s0), 64'd4);

        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
            start(ra, rb);
            wait_idle();
        end

        tick(3);
        check("pending", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Sequential signed multiplier for the multicycle datapath; complementary partner of the shift-subtract divider, sharing its hi/lo result convention and its init/stop handshake with the control unit.
- Radix-2 Booth: one partial-product step per clock, 32 steps per operation.
- Full 64-bit two's-complement product: upper half on hi, lower half on lo, for the MULT/MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits, and hi/lo are WIDTH each.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; sampled only at posedge clk.
- value_A  input  WIDTH  multiplicand, signed.
- value_B  input  WIDTH  multiplier, signed.
- multInit  input  1  start request from the control unit; level-sampled.
- multStop  output  1  done strobe; one-cycle pulse when hi/lo are valid.
- busy  output  1  high while an operation is in progress.
- hi  output  WIDTH  product bits [2W-1:W].
- lo  output  WIDTH  product bits [W-1:0].

Behaviour:
- Reset: reset=0 at a posedge takes priority over everything.
  - Registers: state=IDLE; hi=0, lo=0; multStop=0; busy=0; step counter=0; internal A/Q/M/q-1 = 0.
  - Reset mid-operation aborts the operation; no multStop is produced.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended value_A.
  - A: WIDTH+1 bits, accumulator, so A-M never overflows when M is the most negative value.
  - Q: WIDTH bits, multiplier/product-low.
  - q-1: 1 bit.
  - cnt: ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, multStop=0.
  - When multInit=1 at posedge: M<=sext(value_A), Q<=value_B, A<=0, q-1<=0, cnt<=0, go to RUN.
  - Operands are captured only on this edge; later operand changes have no effect.
- RUN: busy=1. Each posedge performs one Booth step:
  - Examine {Q[0], q-1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no add.
  - Then arithmetic right shift of {A,Q,q-1} by 1, with A's MSB replicated.
  - cnt<=cnt+1.
- Final step (cnt=WIDTH-1):
  - Same edge also loads hi<=new A[WIDTH-1:0], lo<=new Q.
  - Sets multStop<=1 and goes to DONE.
- DONE: multStop=1 and busy=0 for exactly one cycle; next posedge returns to IDLE with multStop<=0.
- Latency: accept edge E0 -> multStop high in the cycle after edge E0+WIDTH (32 step edges). Result is valid in that same cycle and held until the next completion or reset.
- hi/lo do not change during RUN. Previous results remain readable until the final step.
- multInit while RUN or DONE is ignored, with no restart or queueing. multInit still high on the IDLE cycle after DONE starts a new operation; the control unit must drop multInit upon seeing multStop.
- Arithmetic:
  - Result is the exact signed 2W-bit product for all operand pairs, including most-negative x most-negative.
  - No overflow flag is produced.
- No divide-by-zero-style special cases; zero operands run the full 32 steps.

Test Plan:
- Reset low 2 cycles, then multInit=1 with A=3, B=5 -> busy high for 32 cycles, then multStop pulse exactly 1 cycle; hi=0x00000000, lo=0x0000000F.
- A=-7 (0xFFFFFFF9), B=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; then A=-1, B=-1 -> hi=0, lo=1.
- A=B=0x80000000 -> hi=0x40000000, lo=0x00000000; A=0x7FFFFFFF, B=0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Pulse multInit again at step 10 with A=9, B=9, and change value_A/value_B mid-run -> the first result (3*5=15) is unaffected; only one multStop occurs; no second operation starts.
- Start 3*5, drive reset=0 at step 20 -> hi=lo=0, busy=0, no multStop; restart with 4*4 -> lo=0x10 after the full latency.
- Hold multInit=1 continuously with A=2, B=2 -> back-to-back operations, each with 32 busy cycles + 1 DONE cycle + 1 IDLE cycle; lo=4 on every multStop.
